bcd_to_bin: RTL and testbench

Sequential 2-digit BCD to binary converter. It implements reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more. It is the inverse of the binary-to-BCD datapath/control pair and sits after the digit-entry and display logic, where it turns a units/tens pair (0..99) back into a 7-bit binary value. The FSM and the datapath are in one module.

---
 rtl/bcd_to_bin.sv | 97 +++++++++
 tb/tb_bcd_to_bin.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential 2-digit BCD to 7-bit binary converter (reverse double-dabble).
// Shift right, then subtract 3 from each BCD digit that reaches 8 or more.
module bcd_to_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_init,
    input  logic [3:0] in_UND,
    input  logic [3:0] in_DEC,
    output logic [6:0] out_BIN,
    output logic       out_BUSY,
    output logic       out_DONE,
    output logic       out_ERR
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CORRECT = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [14:0] r;
    logic [2:0]  k;
    logic        digits_ok;
    logic [3:0]  dec_c;
    logic [3:0]  und_c;

    assign digits_ok = (in_UND <= 4'd9) && (in_DEC <= 4'd9);

    // Per-digit correction, no borrow between the two nibbles
    always_comb begin
        dec_c = r[14:11];
        und_c = r[10:7];
        if (r[14:11] >= 4'd8) dec_c = r[14:11] - 4'd3;
        if (r[10:7]  >= 4'd8) und_c = r[10:7]  - 4'd3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE: begin
                state_nx = IDLE;
                if (in_init) state_nx = digits_ok ? SHIFT : ERROR;
            end
            SHIFT:   state_nx = CORRECT;
            CORRECT: state_nx = (k == 3'd7) ? DONE : SHIFT;
            DONE:    state_nx = in_init ? DONE : IDLE;
            ERROR:   state_nx = in_init ? ERROR : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_BUSY = (state == SHIFT) || (state == CORRECT);
        out_DONE = (state == DONE);
        out_ERR  = (state == ERROR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r       <= '0;
            k       <= '0;
            out_BIN <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_init) begin
                        if (digits_ok) begin
                            r <= {in_DEC, in_UND, 7'd0};
                            k <= '0;
                        end else begin
                            out_BIN <= '0;
                        end
                    end
                end
                SHIFT: begin
                    r <= {1'b0, r[14:1]};
                    k <= k + 3'd1;
                end
                CORRECT: begin
                    r <= {dec_c, und_c, r[6:0]};
                    if (k == 3'd7) out_BIN <= r[6:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized scoreboard bench for bcd_to_bin: expected results are queued at
// start, and a monitor pops them when out_DONE or out_ERR rises.
module tb_bcd_to_bin;

    logic       clk;
    logic       rst;
    logic       in_init;
    logic [3:0] in_UND;
    logic [3:0] in_DEC;
    logic [6:0] out_BIN;
    logic       out_BUSY;
    logic       out_DONE;
    logic       out_ERR;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int last_bin = 0;
    bit pd = 0;
    bit pe = 0;

    bcd_to_bin dut (
        .clk     (clk),
        .rst     (rst),
        .in_init (in_init),
        .in_UND  (in_UND),
        .in_DEC  (in_DEC),
        .out_BIN (out_BIN),
        .out_BUSY(out_BUSY),
        .out_DONE(out_DONE),
        .out_ERR (out_ERR)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected encoding: bit 7 = error flag, bits 6:0 = binary value
    function automatic int model(input int dec, input int und);
        if (dec > 9 || und > 9) return 128;
        return dec * 10 + und;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            pd = 0;
            pe = 0;
        end else begin
            if ((out_DONE && !pd) || (out_ERR && !pe)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got bin=%0d err=%0d with empty queue", out_BIN, out_ERR);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("result_err", int'(out_ERR), e / 128);
                    chk("result_bin", int'(out_BIN), e % 128);
                end
            end
            pd = out_DONE;
            pe = out_ERR;
        end
    end

    task automatic run(input int dec, input int und, input int hold, input bit perturb);
        int n;
        int bad;
        int e;
        bit ok;
        e  = model(dec, und);
        ok = (e < 128);
        @(negedge clk);
        in_DEC  = 4'(dec);
        in_UND  = 4'(und);
        in_init = 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        n   = 0;
        bad = 0;
        while (!out_DONE && !out_ERR && n < 40) begin
            if (!out_BUSY || int'(out_BIN) != last_bin) bad++;
            if (perturb && n == 3) begin
                in_DEC  = 4'd3;
                in_UND  = 4'd3;
                in_init = 0;
            end
            if (perturb && n == 6) in_init = 1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, ok ? 14 : 0);
        chk("busy_stable", bad, 0);
        last_bin = ok ? e : 0;
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (!out_DONE || out_BUSY || int'(out_BIN) != last_bin) bad++;
            end
            chk("done_hold", bad, 0);
        end
        @(negedge clk);
        in_init = 0;
        @(posedge clk);
        #1;
        chk("idle_flags", {out_BUSY, out_DONE, out_ERR}, 0);
        chk("bin_hold", int'(out_BIN), last_bin);
    endtask

    initial begin
        rst     = 0;
        in_init = 0;
        in_UND  = 0;
        in_DEC  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {out_BUSY, out_DONE, out_ERR}, 0);
        chk("reset_bin", int'(out_BIN), 0);
        @(negedge clk);
        rst = 1;

        run(9, 9, 0, 0);
        run(1, 0, 0, 0);
        run(0, 0, 0, 0);
        run(5, 7, 0, 1);
        run(10, 2, 0, 0);
        run(4, 2, 0, 0);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        in_DEC  = 4'd7;
        in_UND  = 4'd3;
        in_init = 1;
        exp_q.push_back(model(7, 3));
        repeat (6) @(posedge clk);
        #2;
        rst = 0;
        #1;
        chk("abort_flags", {out_BUSY, out_DONE, out_ERR}, 0);
        chk("abort_bin", int'(out_BIN), 0);
        exp_q.delete();
        last_bin = 0;
        in_init  = 0;
        @(negedge clk);
        rst = 1;
        run(2, 5, 10, 0);

        for (int t = 0; t < 40; t++) begin
            int d;
            int u;
            int h;
            d = $urandom_range(0, 11);
            u = $urandom_range(0, 11);
            h = (d <= 9 && u <= 9) ? $urandom_range(0, 2) : 0;
            run(d, u, h, bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
